// File: rtl/audio_in_level_meter.sv
// audio_in_level_meter
// Drains L/R microphone samples from the Audio_Controller input FIFO.
// Each sample is mixed to mono and fed into a decaying peak envelope.
// The envelope drives a 10-bit thermometer level and a one-cycle onset pulse.
//
// Handshake: in IDLE, a pair is taken when enable && audio_in_available.
// The pair is latched on that edge, and read_audio_in is high for exactly the
// following (WAIT) cycle. Outputs are registered on the WAIT->PROC edge.
// sample_valid/onset are high for the PROC cycle only.
//
// Optional build macro: AUDIO_IN_DC_BLOCK_EN. When defined, a first-order
// DC-blocking high-pass filter sits ahead of the magnitude stage.
module audio_in_level_meter #(
  parameter int          DECAY_SHIFT  = 10,
  parameter logic [30:0] ONSET_THRESH = 31'h0400_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        clear_audio_in_memory,
  output logic        sample_valid,
  output logic [31:0] sample_mono,
  output logic [30:0] peak,
  output logic [9:0]  level,
  output logic        onset,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PROC = 2'd2
  } state_t;

  localparam logic [30:0] REARM_THRESH = ONSET_THRESH >> 1;

  state_t             state_q, state_d;
  logic signed [31:0] cap_l, cap_r;
  logic               armed;

  logic signed [31:0] mono_c;
  logic [30:0]        mag_c;
  logic [30:0]        peak_c;
  logic [9:0]         level_c;
  logic               fire_c;
  logic               rearm_c;

`ifdef AUDIO_IN_DC_BLOCK_EN
  logic signed [31:0] dc_q;
  logic signed [32:0] x_c;
  logic signed [32:0] x_abs_c;
  logic signed [31:0] dc_c;
`endif

  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state. A sample is only taken from IDLE. Once latched, it always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable && audio_in_available) state_d = S_WAIT;
      S_WAIT:  state_d = S_PROC;
      S_PROC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the L/R pair on the edge that leaves IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cap_l <= '0;
      cap_r <= '0;
    end else if (state_q == S_IDLE && state_d == S_WAIT) begin
      cap_l <= left_channel_audio_in;
      cap_r <= right_channel_audio_in;
    end
  end

  // Mono mix and magnitude. Halving before the add keeps the sum in range.
  always_comb begin
    mono_c = (cap_l >>> 1) + (cap_r >>> 1);
`ifdef AUDIO_IN_DC_BLOCK_EN
    x_c     = {mono_c[31], mono_c} - {dc_q[31], dc_q};
    x_abs_c = x_c[32] ? -x_c : x_c;
    dc_c    = dc_q + 32'(x_c >>> 8);
    if (x_abs_c > 33'sh0_7FFF_FFFF) mag_c = 31'h7FFF_FFFF;
    else                            mag_c = x_abs_c[30:0];
`else
    if (mono_c == 32'sh8000_0000) mag_c = 31'h7FFF_FFFF;
    else if (mono_c[31])          mag_c = 31'((-mono_c));
    else                          mag_c = mono_c[30:0];
`endif
  end

  // Envelope, thermometer and onset decision for the sample in flight.
  always_comb begin
    if (mag_c > peak) peak_c = mag_c;
    else              peak_c = peak - (peak >> DECAY_SHIFT);
    level_c = '0;
    for (int i = 0; i < 10; i++) begin
      level_c[i] = |(peak_c >> (21 + i));
    end
    fire_c  = armed && (peak_c >= ONSET_THRESH);
    rearm_c = !armed && (peak_c < REARM_THRESH);
  end

  // Handshake strobes. The FIFO is held cleared whenever the meter idles while disabled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      read_audio_in         <= 1'b0;
      clear_audio_in_memory <= 1'b1;
    end else begin
      read_audio_in         <= (state_q == S_IDLE) && (state_d == S_WAIT);
      clear_audio_in_memory <= (state_d == S_IDLE) && !enable;
    end
  end

  // Result registers, loaded as the FSM enters PROC.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sample_valid <= 1'b0;
      sample_mono  <= '0;
      peak         <= '0;
      level        <= '0;
      onset        <= 1'b0;
      armed        <= 1'b1;
    end else begin
      sample_valid <= (state_q == S_WAIT);
      onset        <= (state_q == S_WAIT) && fire_c;
      if (state_q == S_WAIT) begin
        sample_mono <= mono_c;
        peak        <= peak_c;
        level       <= level_c;
        if (fire_c)       armed <= 1'b0;
        else if (rearm_c) armed <= 1'b1;
      end
    end
  end

`ifdef AUDIO_IN_DC_BLOCK_EN
  // DC estimate tracks the slow mean of the mono stream.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                dc_q <= '0;
    else if (state_q == S_WAIT) dc_q <= dc_c;
  end
`endif

endmodule

// File: tb/tb_audio_in_level_meter.sv
// Testbench for audio_in_level_meter: a directed sequence with a reference model and an expected-result queue.
module tb_audio_in_level_meter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        clear_audio_in_memory;
  logic        sample_valid;
  logic [31:0] sample_mono;
  logic [30:0] peak;
  logic [9:0]  level;
  logic        onset;
  logic [1:0]  state_dbg;

  audio_in_level_meter dut (
    .clock                  (clock),
    .resetn                 (resetn),
    .enable                 (enable),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .clear_audio_in_memory  (clear_audio_in_memory),
    .sample_valid           (sample_valid),
    .sample_mono            (sample_mono),
    .peak                   (peak),
    .level                  (level),
    .onset                  (onset),
    .state_dbg              (state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model
  logic signed [31:0] m_dc = 0;
  logic [30:0]        m_peak = 0;
  logic               m_armed = 1'b1;

  // {mono[31:0], peak[30:0], level[9:0], onset}
  logic [73:0] exp_q[$];

  function automatic logic [9:0] lvl_of(input logic [30:0] p);
    logic [9:0] l;
    for (int i = 0; i < 10; i++) l[i] = (p >> (21 + i)) != 0;
    return l;
  endfunction

  task automatic model_push(input logic [31:0] l, input logic [31:0] r);
    logic signed [31:0] mono;
    logic signed [32:0] x;
    logic [30:0]        mag;
    logic               on;
    mono = ($signed(l) >>> 1) + ($signed(r) >>> 1);
`ifdef AUDIO_IN_DC_BLOCK_EN
    x    = $signed({mono[31], mono}) - $signed({m_dc[31], m_dc});
    m_dc = m_dc + 32'(x >>> 8);
`else
    x = $signed({mono[31], mono});
`endif
    if (x < 0) x = -x;
    mag = (x > 33'sh0_7FFF_FFFF) ? 31'h7FFF_FFFF : x[30:0];
    if (mag > m_peak) m_peak = mag;
    else              m_peak = m_peak - (m_peak >> 10);
    on = 1'b0;
    if (m_armed && m_peak >= 31'h0400_0000) begin
      on = 1'b1;
      m_armed = 1'b0;
    end else if (!m_armed && m_peak < 31'h0200_0000) begin
      m_armed = 1'b1;
    end
    exp_q.push_back({mono, m_peak, lvl_of(m_peak), on});
  endtask

  // Monitor / scoreboard
  logic [31:0] lat_l = 0, lat_r = 0;
  logic        prev_rd = 1'b0;
  int          cyc = 0;
  int          reads_seen = 0;
  int          onsets_seen = 0;
  int          valids_seen = 0;
  int          last_rd = -1;
  logic        stream_chk = 1'b0;

  // The L/R values present at each rising edge are what the DUT latches.
  always @(posedge clock) begin
    lat_l = left_channel_audio_in;
    lat_r = right_channel_audio_in;
  end

  always @(negedge clock) begin
    logic [73:0] e;
    cyc++;
    if (resetn !== 1'b1) begin
      prev_rd = 1'b0;
    end else begin
      if (read_audio_in === 1'b1) begin
        chk("read_not_back_to_back", prev_rd, 1'b0);
        reads_seen++;
        model_push(lat_l, lat_r);
        if (stream_chk && last_rd >= 0) chk("read_gap", cyc - last_rd, 3);
        last_rd = cyc;
      end
      if (sample_valid === 1'b1) begin
        valids_seen++;
        chk("valid_after_read", prev_rd, 1'b1);
        chk("queue_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sample_mono", sample_mono, e[73:42]);
          chk("peak", peak, e[41:11]);
          chk("level", level, e[10:1]);
          chk("onset", onset, e[0]);
        end
        if (onset === 1'b1) onsets_seen++;
      end else begin
        chk("onset_idle", onset, 1'b0);
      end
      prev_rd = read_audio_in;
    end
  end

  // Driver tasks
  task automatic send(input logic [31:0] l, input logic [31:0] r);
    int n;
    @(posedge clock); #1;
    left_channel_audio_in  = l;
    right_channel_audio_in = r;
    audio_in_available     = 1'b1;
    n = 0;
    while (read_audio_in !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("send_read_timeout", read_audio_in, 1'b1);
    audio_in_available = 1'b0;
    n = 0;
    while (sample_valid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("send_valid_timeout", sample_valid, 1'b1);
  endtask

  task automatic stream(input logic [31:0] l, input logic [31:0] r, input int count);
    int got, n;
    @(posedge clock); #1;
    last_rd    = -1;
    stream_chk = 1'b1;
    left_channel_audio_in  = l;
    right_channel_audio_in = r;
    audio_in_available     = 1'b1;
    got = 0; n = 0;
    while (got < count && n < 20 * count) begin
      @(posedge clock); #1; n++;
      if (read_audio_in === 1'b1) got++;
    end
    chk("stream_read_count", got, count);
    audio_in_available = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    stream_chk = 1'b0;
  endtask

  initial begin
    int r0, o0, v0, n;
    resetn = 1'b0;
    enable = 1'b1;
    audio_in_available = 1'b0;
    left_channel_audio_in  = 0;
    right_channel_audio_in = 0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_read", read_audio_in, 1'b0);
    chk("rst_clear", clear_audio_in_memory, 1'b1);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_mono", sample_mono, 32'h0);
    chk("rst_peak", peak, 31'h0);
    chk("rst_level", level, 10'h0);
    chk("rst_onset", onset, 1'b0);
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("clear_drop", clear_audio_in_memory, 1'b0);
    r0 = reads_seen;
    repeat (100) @(posedge clock);
    #1;
    chk("no_read_idle", reads_seen - r0, 0);

    // First sample: explicit values
    send(32'h1000_0000, 32'h1000_0000);
    chk("first_mono", sample_mono, 32'h1000_0000);
    chk("first_peak", peak, 31'h1000_0000);
    chk("first_level", level, 10'h0FF);
    chk("first_onset", onset, 1'b1);

    // Decay over five silent samples
    send(0, 0);
    chk("decay_first", peak, 31'h0FFC_0000);
    for (int i = 0; i < 4; i++) begin
      logic [9:0] pl;
      pl = level;
      send(0, 0);
      chk("decay_level_monotone", level <= pl, 1'b1);
    end

    // Continuous availability: pops every third cycle
    stream(32'h1000_0000, 32'h1000_0000, 4);
    stream(32'h0123_4567, 32'hF000_0001, 3);

    // Saturation; onset already consumed, so no new pulse
    o0 = onsets_seen;
    send(32'h8000_0000, 32'h8000_0000);
    chk("sat_mono", sample_mono, 32'h8000_0000);
    chk("sat_peak", peak, 31'h7FFF_FFFF);
    chk("sat_level", level, 10'h3FF);
    send(32'h8000_0000, 32'h8000_0000);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    chk("no_onset_unarmed", onsets_seen - o0, 0);

    // Decay until the model re-arms, then one loud sample fires exactly once
    n = 0;
    while (!m_armed && n < 6000) begin send(0, 0); n++; end
    chk("rearm_reached", m_armed, 1'b1);
    chk("rearm_peak_below", peak < 31'h0200_0000, 1'b1);
    o0 = onsets_seen;
    send(32'h8000_0000, 32'h8000_0000);
    send(32'h8000_0000, 32'h8000_0000);
    chk("onset_once", onsets_seen - o0, 1);

    // enable low with data available: FIFO cleared, no pops
    @(posedge clock); #1;
    enable = 1'b0;
    audio_in_available = 1'b1;
    left_channel_audio_in  = 32'h0000_4000;
    right_channel_audio_in = 32'h0000_4000;
    repeat (4) @(posedge clock);
    #1;
    chk("dis_clear", clear_audio_in_memory, 1'b1);
    r0 = reads_seen;
    v0 = peak;
    repeat (20) @(posedge clock);
    #1;
    chk("dis_no_read", reads_seen - r0, 0);
    chk("dis_peak_held", peak, v0);
    enable = 1'b1;
    @(posedge clock); #1;
    chk("en_read_resume", read_audio_in, 1'b1);
    audio_in_available = 1'b0;
    repeat (4) @(posedge clock);

    // Reset during WAIT discards the sample in flight
    @(posedge clock); #1;
    audio_in_available = 1'b1;
    left_channel_audio_in  = 32'h2000_0000;
    right_channel_audio_in = 32'h2000_0000;
    n = 0;
    while (read_audio_in !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    chk("wait_reached", state_dbg, 2'd1);
    resetn = 1'b0;
    audio_in_available = 1'b0;
    #1;
    chk("abort_read", read_audio_in, 1'b0);
    chk("abort_valid", sample_valid, 1'b0);
    chk("abort_clear", clear_audio_in_memory, 1'b1);
    exp_q.delete();
    m_peak  = 0;
    m_armed = 1'b1;
    m_dc    = 0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    v0 = valids_seen;
    repeat (10) @(posedge clock);
    #1;
    chk("no_valid_after_abort", valids_seen - v0, 0);
    chk("abort_peak_cleared", peak, 31'h0);

    // One clean sample after the abort
    send(32'h0040_0000, 32'hFFC0_0000);
    chk("post_abort_mono", sample_mono, 32'h0);
    repeat (3) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/audio_in_level_meter.md
Name: audio_in_level_meter

Overview:
- Capture-side companion to the tone generator: drains microphone samples from the Audio_Controller input FIFO using the audio_in_available / read_audio_in handshake.
- Mixes the two channels to mono and tracks a decaying peak envelope.
- Drives a 10-bit thermometer level (for LEDR) and a one-cycle onset pulse for sound-triggered note events.
- Sits beside Wave_Generator in LaunchPad, on the input ports of the same Audio_Controller.

Parameters:
- DECAY_SHIFT, 10: per-sample envelope decay is peak >> DECAY_SHIFT.
- ONSET_THRESH, 31'h0400_0000: peak level that fires onset; re-arm level is ONSET_THRESH >> 1.

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = meter runs; 0 = FIFO held cleared, no reads.
- audio_in_available  in  1  Audio_Controller: at least one L/R pair is readable.
- left_channel_audio_in  in  32  signed left sample, valid while available=1.
- right_channel_audio_in  in  32  signed right sample, valid while available=1.
- read_audio_in  out  1  one-cycle pop strobe to Audio_Controller.
- clear_audio_in_memory  out  1  FIFO clear to Audio_Controller.
- sample_valid  out  1  one-cycle pulse: sample_mono and peak updated.
- sample_mono  out  32  signed mono sample.
- peak  out  31  unsigned envelope.
- level  out  10  thermometer level.
- onset  out  1  one-cycle pulse on threshold crossing.

Behaviour:
- Reset (resetn=0, async): all outputs 0 except clear_audio_in_memory=1; FSM=IDLE; armed=1. The first clock edge after release drives clear_audio_in_memory to 0. Assertion mid-transaction aborts immediately; a partially captured sample is discarded.
- FSM states and transitions:
  - IDLE: if enable && audio_in_available, latch L/R into capture registers, assert read_audio_in (registered, so high exactly during the WAIT cycle), go to WAIT.
  - WAIT: one cycle for the FIFO flags to update; read_audio_in returns to 0; go to PROC.
  - PROC: update mono, peak, level and armed; pulse sample_valid; go to IDLE.
  - Result: at most one pop per 3 cycles. read_audio_in is never high on two consecutive cycles.
- enable=0:
  - In IDLE: stay in IDLE, clear_audio_in_memory=1, no reads.
  - In WAIT or PROC: finish the in-flight sample first.
  - peak is held, not cleared.
- Mono: mono = (L >>> 1) + (R >>> 1), signed 32-bit. Cannot overflow.
- Magnitude: mag = |mono| as 31-bit unsigned. mono = -2^31 saturates to 31'h7FFF_FFFF.
- Envelope, at each PROC:
  - If mag > peak: peak <= mag.
  - Otherwise: peak <= peak - (peak >> DECAY_SHIFT). This goes non-increasing; peak < 2^DECAY_SHIFT stops decaying, which is accepted.
- Level: level[i] = |peak[30:21+i] for i = 0..9, updated with peak, giving a monotone thermometer. peak < 2^21 gives level = 0; peak >= 2^30 gives level = 10'h3FF.
- Onset, evaluated on the new peak at PROC:
  - If armed && peak >= ONSET_THRESH: onset=1 for that cycle, armed <= 0.
  - If !armed && peak < (ONSET_THRESH >> 1): armed <= 1.
  - Crossing and re-arm never happen in the same PROC.
- Simultaneous events: available dropping during WAIT/PROC is ignored; an already-latched sample is always completed.

Optional Feature:
- Macro: AUDIO_IN_DC_BLOCK_EN.
- Defined: a DC-blocking high-pass is inserted before the magnitude stage.
  - Internal 32-bit signed dc register, reset 0.
  - At PROC: x = mono - dc; dc <= dc + (x >>> 8); mag computed from x with 33-bit intermediate and saturation to 31'h7FFF_FFFF.
  - sample_mono still reports the raw mono value.
- Undefined: mag is computed from mono directly; no dc register is synthesised.

Test Plan:
- Reset: hold resetn=0 → all outputs 0, clear_audio_in_memory=1. Release → clear drops after the first edge; with available=0, read_audio_in stays 0 for 100 cycles.
- Handshake with available held 1 and L=R=32'h1000_0000:
  - read_audio_in pulses every 3rd cycle; sample_valid follows each read by 1 cycle.
  - sample_mono=32'h1000_0000, peak=31'h1000_0000, level=10'h0FF.
- Decay: after peak=31'h1000_0000, feed 5 samples of L=R=0 with no DC block → peak reduces by >>10 each sample (first value 31'h0FFC_0000); level never increases.
- Saturation/onset: L=R=32'h8000_0000 → mono=-2^31, peak=31'h7FFF_FFFF, level=10'h3FF. onset pulses exactly once; further loud samples give no onset until peak < 31'h0200_0000.
- enable=0 while available=1 → clear_audio_in_memory=1, no read strobes. Reassert enable → reads resume within 1 cycle.
- Async reset asserted during WAIT → read_audio_in and sample_valid drop immediately; no sample_valid pulse follows release.
